// File: rtl/vball_sprite_ram_if.sv
// Bus bundle between the CPU decode / sprite renderer (master) and the sprite RAM (slave).
interface vball_sprite_ram_if #(
  parameter int AW = 8
);
  // No valid/ready: cpu_we is a plain per-cycle write strobe, reads are unconditional every
  // cycle, and cpu_dout/smd always return the addressed byte one clock after the address.
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_we;
  logic [7:0]    cpu_dout;
  logic          vblank;
  logic [AW-1:0] sma;
  logic [7:0]    smd;
  logic          copy_busy;
  logic [7:0]    frame_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output cpu_addr, cpu_din, cpu_we, vblank, sma,
    input  cpu_dout, smd, copy_busy, frame_cnt, dbg_state
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, vblank, sma,
    output cpu_dout, smd, copy_busy, frame_cnt, dbg_state
  );
endinterface

// File: rtl/vball_sprite_ram.sv
// Sprite attribute RAM: CPU-written shadow table copied to the renderer's display table on vblank.
// Define SPRITE_RAM_DBUF_EN for the double-buffered copy; otherwise one shared array, edges only counted.
module vball_sprite_ram #(
  parameter int AW           = 8,
  parameter bit COPY_ON_EDGE = 1'b1
) (
  input logic               clk_sys,
  input logic               reset,
  vball_sprite_ram_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_vb_d;
  logic [AW:0] r_ptr;
  logic        r_copy_busy;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_cpu_dout;
  logic [7:0]  r_smd;
  logic        w_trigger;
  logic [7:0]  w_cpu_rd;
  logic [7:0]  w_ren_rd;

  assign w_trigger = COPY_ON_EDGE ? (bus.vblank & ~r_vb_d) : (~bus.vblank & r_vb_d);

`ifdef SPRITE_RAM_DBUF_EN
  localparam state_t S_START = S_COPY;

  logic [7:0]    r_shadow  [DEPTH];
  logic [7:0]    r_display [DEPTH];
  logic [7:0]    r_copy_data;
  logic [AW-1:0] w_wr_idx;

  // ptr = 2^AW wraps the low bits to 0, so the final write lands on the last byte.
  assign w_wr_idx = r_ptr[AW-1:0] - AW'(1);
  assign w_cpu_rd = r_shadow[bus.cpu_addr];
  assign w_ren_rd = r_display[bus.sma];

  always_ff @(posedge clk_sys) begin
    if (bus.cpu_we) r_shadow[bus.cpu_addr] <= bus.cpu_din;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset && r_state == S_COPY) begin
      if (!r_ptr[AW]) r_copy_data <= r_shadow[r_ptr[AW-1:0]];
      if (r_ptr != '0) r_display[w_wr_idx] <= r_copy_data;
    end
  end
`else
  localparam state_t S_START = S_DONE;

  logic [7:0] r_mem [DEPTH];

  assign w_cpu_rd = r_mem[bus.cpu_addr];
  assign w_ren_rd = r_mem[bus.sma];

  always_ff @(posedge clk_sys) begin
    if (bus.cpu_we) r_mem[bus.cpu_addr] <= bus.cpu_din;
  end
`endif

  // vb_d is left unreset so a vblank already high across reset does not look like a new edge.
  always_ff @(posedge clk_sys) begin
    r_vb_d <= bus.vblank;
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_copy_busy <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_cpu_dout  <= 8'd0;
      r_smd       <= 8'd0;
    end else begin
      r_cpu_dout <= w_cpu_rd;
      r_smd      <= w_ren_rd;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_ptr       <= '0;
            r_copy_busy <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_COPY: begin
          // Busy drops as the last byte is written, giving exactly 2^AW+1 busy cycles.
          if (r_ptr[AW]) begin
            r_copy_busy <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_ptr <= r_ptr + (AW+1)'(1);
          end
        end
        S_DONE: begin
          r_copy_busy <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_dout  = r_cpu_dout;
  assign bus.smd       = r_smd;
  assign bus.copy_busy = r_copy_busy;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_vball_sprite_ram.sv
// Directed-sequence bench for vball_sprite_ram with a table-level reference model.
// Builds with or without SPRITE_RAM_DBUF_EN; the model follows the same define.
module tb_vball_sprite_ram;
  logic clk_sys = 1'b0;
  logic reset;

  always #5 clk_sys = ~clk_sys;

  vball_sprite_ram_if #(.AW(8)) bus ();

  vball_sprite_ram #(.AW(8), .COPY_ON_EDGE(1'b1)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

`ifdef SPRITE_RAM_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         frames_m = 0;
  logic [7:0] shad_m [256];
  logic [7:0] disp_m [256];
  logic [7:0] snap_m [256];
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] v);
    bus.cpu_addr = a;
    bus.cpu_din  = v;
    bus.cpu_we   = 1'b1;
    tick();
    bus.cpu_we   = 1'b0;
    shad_m[a] = v;
    if (!DBUF) disp_m[a] = v;
  endtask

  // A write landing while a copy runs reaches this frame only if its byte is not yet read.
  function automatic void model_copy_write(input logic [7:0] a, input logic [7:0] v, input int k);
    shad_m[a] = v;
    if (DBUF && int'(a) > k) snap_m[a] = v;
  endfunction

  task automatic model_copy_done();
    if (DBUF) disp_m = snap_m;
    frames_m++;
  endtask

  task automatic scan_disp(input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) begin
      bus.sma = 8'(a);
      exp_q.push_back(disp_m[a]);
      tick();
      check(tag, bus.smd, exp_q.pop_front());
    end
  endtask

  task automatic scan_shad(input string tag);
    for (int a = 0; a < 256; a++) begin
      bus.cpu_addr = 8'(a);
      exp_q.push_back(shad_m[a]);
      tick();
      check(tag, bus.cpu_dout, exp_q.pop_front());
    end
  endtask

  // mode 0: plain copy, 1: CPU writes mid-copy, 2: vblank re-edge mid-copy, 3: reset mid-copy
  task automatic run_copy(input int mode, output int len);
    int k;
    int wait_n;
    bus.vblank = 1'b1;
    snap_m = shad_m;
    wait_n = 0;
    while (bus.copy_busy !== 1'b1 && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("copy_start", {31'd0, bus.copy_busy}, 32'd1);
    k = 0;
    while (bus.copy_busy === 1'b1 && k < 600) begin
      if (mode == 1 && k == 'h80) begin
        bus.cpu_addr = 8'h10; bus.cpu_din = 8'h33; bus.cpu_we = 1'b1;
        model_copy_write(8'h10, 8'h33, k);
      end
      if (mode == 1 && k == 'h81) begin
        bus.cpu_addr = 8'hF0; bus.cpu_din = 8'h44; bus.cpu_we = 1'b1;
        model_copy_write(8'hF0, 8'h44, k);
      end
      if (mode == 1 && k == 'h82) bus.cpu_we = 1'b0;
      if (mode == 2 && k == 90) bus.vblank = 1'b0;
      if (mode == 2 && k == 100) bus.vblank = 1'b1;
      if (mode == 3 && k == 50) reset = 1'b1;
      tick();
      k++;
    end
    bus.cpu_we = 1'b0;
    len = k;
  endtask

  initial begin
    int len;
    int busy_seen;
    int exp_len;
    logic [7:0] old_sh;
    logic [7:0] old_dp;

    exp_len = DBUF ? 257 : 1;
    reset = 1'b1;
    bus.cpu_addr = 8'h00;
    bus.cpu_din  = 8'h00;
    bus.cpu_we   = 1'b0;
    bus.vblank   = 1'b0;
    bus.sma      = 8'h05;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_smd", bus.smd, 8'h00);
    check("rst_cpu_dout", bus.cpu_dout, 8'h00);
    check("rst_busy", {31'd0, bus.copy_busy}, 32'd0);
    check("rst_frame", bus.frame_cnt, 8'h00);

    for (int a = 0; a < 256; a++) cpu_write(8'(a), 8'($urandom_range(0, 255)));
    scan_shad("shadow_fill");

    run_copy(0, len);
    check("busy_len_first", len, exp_len);
    bus.vblank = 1'b0;
    tick(); tick();
    model_copy_done();
    check("frame_first", bus.frame_cnt, frames_m);
    scan_disp(0, 255, "disp_first");

    cpu_write(8'h01, 8'h87);
    scan_disp(1, 1, "smd_before_copy");
    run_copy(0, len);
    check("busy_len_0x87", len, exp_len);
    bus.vblank = 1'b0;
    tick(); tick();
    model_copy_done();
    check("frame_0x87", bus.frame_cnt, frames_m);
    bus.sma = 8'h01;
    tick();
    check("smd_0x87", bus.smd, 8'h87);

    cpu_write(8'h10, 8'h11);
    cpu_write(8'hF0, 8'h22);
    run_copy(1, len);
    check("busy_len_midwrite", len, exp_len);
    bus.vblank = 1'b0;
    tick(); tick();
    model_copy_done();
    check("frame_midwrite", bus.frame_cnt, frames_m);
    scan_disp(0, 255, "disp_midwrite");

    // Second copy, then hold vblank high: no further copy may start.
    run_copy(0, len);
    check("busy_len_second", len, exp_len);
    busy_seen = 0;
    repeat (300) begin
      tick();
      if (bus.copy_busy === 1'b1) busy_seen++;
    end
    check("held_high_no_retrigger", busy_seen, 0);
    model_copy_done();
    check("frame_held_high", bus.frame_cnt, frames_m);
    scan_disp(0, 255, "disp_second");
    bus.vblank = 1'b0;
    tick();

    run_copy(2, len);
    check("busy_len_reedge", len, exp_len);
    tick(); tick();
    model_copy_done();
    check("frame_reedge", bus.frame_cnt, frames_m);
    bus.vblank = 1'b0;
    tick();

    for (int a = 0; a < 256; a++) cpu_write(8'(a), ~disp_m[a]);
    run_copy(3, len);
    check("reset_abort_len", len, DBUF ? 51 : 1);
    bus.vblank = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (DBUF) for (int a = 0; a <= 'h30; a++) disp_m[a] = snap_m[a];
    frames_m = 0;
    check("reset_busy", {31'd0, bus.copy_busy}, 32'd0);
    check("reset_frame", bus.frame_cnt, frames_m);
    scan_disp(0, 'h30, "disp_partial_new");
    scan_disp('h40, 'hFF, "disp_partial_old");

    run_copy(0, len);
    check("busy_len_after_reset", len, exp_len);
    bus.vblank = 1'b0;
    tick(); tick();
    model_copy_done();
    check("frame_after_reset", bus.frame_cnt, frames_m);
    scan_disp(0, 255, "disp_after_reset");

    if (shad_m[8'h22] == 8'h5A) cpu_write(8'h22, 8'hA5);
    old_sh = shad_m[8'h22];
    old_dp = disp_m[8'h22];
    bus.cpu_addr = 8'h22;
    bus.cpu_din  = 8'h5A;
    bus.cpu_we   = 1'b1;
    bus.sma      = 8'h22;
    tick();
    bus.cpu_we = 1'b0;
    shad_m[8'h22] = 8'h5A;
    if (!DBUF) disp_m[8'h22] = 8'h5A;
    check("rbw_cpu_old", bus.cpu_dout, old_sh);
    check("rbw_smd_old", bus.smd, old_dp);
    tick();
    check("rbw_cpu_new", bus.cpu_dout, 8'h5A);
    check("rbw_smd_next", bus.smd, disp_m[8'h22]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
